// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock divider bank.
// Latency: n/a (package only).
// Backpressure: n/a.
//  DIV_W_DEF / NUM_CH_DEF / DEFAULT_DIV_DEF : default parameter values
//  DIV_STOP                                 : divisor value that stops a channel
//  ch_width(n)                              : channel index width, never below 1
package clk_div_pkg;

    localparam int DIV_W_DEF       = 8;
    localparam int NUM_CH_DEF      = 4;
    localparam int DEFAULT_DIV_DEF = 12;
    localparam int DIV_STOP        = 0;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One programmable divider: 50% square wave with half-period div, plus rising-edge tick.
// Latency: outputs are registered; a toggle appears on the edge where cnt reaches div-1.
// Backpressure: none; divisor writes are always accepted (pending until the next toggle).
//  clk, rst_n : system clock, async active-low reset
//  en, sync   : count enable, phase restart (sync wins over en)
//  we, div_in : divisor write strobe and value (0 stops the channel)
//  clk_out, tick, busy : divided clock, 1-cycle rise pulse, divisor pending
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             we,
    input  logic [DIV_W-1:0] div_in,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_pend;
    logic             r_busy;
    logic             r_clk;
    logic             r_tick;

    logic w_stopped;
    logic w_last;
    logic w_pend_stop;

    assign w_stopped   = (r_div == DIV_W'(DIV_STOP));
    // Only evaluated while running, so r_div >= 1 and div-1 cannot wrap.
    assign w_last      = (r_cnt == r_div - DIV_W'(1));
    assign w_pend_stop = (r_pend == DIV_W'(DIV_STOP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= DIV_W'(DEFAULT_DIV);
            r_cnt  <= '0;
            r_pend <= '0;
            r_busy <= 1'b0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else if (sync) begin
            // Restart in phase; anything pending (or written now) takes effect at once.
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
            r_busy <= 1'b0;
            if (we) begin
                r_div <= div_in;
            end else if (r_busy) begin
                r_div <= r_pend;
            end
        end else if (w_stopped) begin
            // A stopped channel has no phase to protect, so writes load directly.
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
            if (we) begin
                r_div <= div_in;
            end
        end else begin
            r_tick <= 1'b0;
            if (en) begin
                if (w_last) begin
                    r_cnt <= '0;
                    if (r_busy) begin
                        r_div  <= r_pend;
                        r_busy <= 1'b0;
                    end
                    if (r_busy && w_pend_stop) begin
                        r_clk <= 1'b0;
                    end else begin
                        r_clk  <= ~r_clk;
                        r_tick <= ~r_clk;
                    end
                end else begin
                    r_cnt <= r_cnt + DIV_W'(1);
                end
            end
            // Placed last so a write on a toggle edge stays pending for the next one.
            if (we) begin
                r_pend <= div_in;
                r_busy <= 1'b1;
            end
        end
    end

    assign clk_out = r_clk;
    assign tick    = r_tick;
    assign busy    = r_busy;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent programmable clock dividers sharing one system clock.
// Latency: cfg_err one cycle after the bad write; divisor changes land at the next toggle.
// Backpressure: none; writes to a valid channel are always taken, invalid ones dropped.
//  clk, rst_n        : system clock, async active-low reset
//  en, sync          : global count enable, global phase restart
//  cfg_we/ch/div     : divisor write strobe, channel index, half-period (0 = stop)
//  cfg_err           : 1-cycle pulse for a write to a nonexistent channel
//  clk_out/tick/busy : per-channel divided clock, rise pulse, divisor pending
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
    parameter int CH_W        = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] busy
);

    logic              w_ch_ok;
    logic [NUM_CH-1:0] w_we;
    logic              r_cfg_err;

    // Compare in int so a non-power-of-two channel count decodes correctly.
    assign w_ch_ok = (int'(cfg_ch) < NUM_CH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && !w_ch_ok;
        end
    end

    assign cfg_err = r_cfg_err;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign w_we[gi] = cfg_we && w_ch_ok && (cfg_ch == CH_W'(gi));

        clk_div_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .sync    (sync),
            .we      (w_we[gi]),
            .div_in  (cfg_div),
            .clk_out (clk_out[gi]),
            .tick    (tick[gi]),
            .busy    (busy[gi])
        );
    end

endmodule
